// File: rtl/vga_clk_pkg.sv
// Shared constants for the video clocking subsystem: sequencer state
// encoding and default timing parameters.
package vga_clk_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_e;

  localparam int CNT_W            = 16;
  localparam int DEF_RST_HOLD     = 16;
  localparam int DEF_LOCK_TIMEOUT = 50000;  // 1 ms at 50 MHz
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_MAX_RETRIES  = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings a PLL out of reset, waits for a stable lock, then releases the
// downstream video reset; retries a bounded number of times before faulting.
module pll_lock_sequencer
  import vga_clk_pkg::*;
#(
  parameter int RST_HOLD     = DEF_RST_HOLD,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRIES - 1);

  seq_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       retry_reg, retry_next;
  logic             pll_rst_reg, sys_rst_n_reg, ready_reg, fault_reg;
  logic             lk;
  logic             fail;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg != '0) ? cnt_reg - CNT_W'(1) : cnt_reg;
    retry_next = retry_reg;
    fail       = 1'b0;
    if (relock_req) begin
      // Restart request beats every other transition, including RUN entry.
      state_next = ST_HOLD;
      cnt_next   = HOLD_LOAD;
      retry_next = '0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (cnt_reg == '0) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = TIMEOUT_LOAD;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk) begin
            state_next = ST_STABILIZE;
            cnt_next   = STABLE_LOAD;
          end else if (cnt_reg == '0) begin
            fail = 1'b1;
          end
        end
        ST_STABILIZE: begin
          // Lock must still be present on the final cycle to count.
          if (!lk) begin
            fail = 1'b1;
          end else if (cnt_reg == '0) begin
            state_next = ST_RUN;
            retry_next = '0;
          end
        end
        ST_RUN: begin
          if (!lk) begin
            state_next = ST_HOLD;
            cnt_next   = HOLD_LOAD;
            retry_next = '0;
          end
        end
        ST_FAULT: begin
        end
        default: begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
          retry_next = '0;
        end
      endcase
      if (fail) begin
        retry_next = (retry_reg == 2'd3) ? 2'd3 : retry_reg + 2'd1;
        if (retry_reg == RETRY_LAST) begin
          state_next = ST_FAULT;
        end else begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_reg     <= ST_HOLD;
      cnt_reg       <= HOLD_LOAD;
      retry_reg     <= '0;
      pll_rst_reg   <= 1'b1;
      sys_rst_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      pll_rst_reg   <= (state_next == ST_HOLD) || (state_next == ST_FAULT);
      sys_rst_n_reg <= (state_next == ST_RUN);
      ready_reg     <= (state_next == ST_RUN);
      fault_reg     <= (state_next == ST_FAULT);
    end
  end

  assign pll_rst   = pll_rst_reg;
  assign sys_rst_n = sys_rst_n_reg;
  assign ready     = ready_reg;
  assign fault     = fault_reg;
  assign retry_cnt = retry_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized and directed bench for pll_lock_sequencer; a deadline-based
// reference model is compared against every output on every cycle.
module tb_pll_lock_sequencer;
  import vga_clk_pkg::*;

  localparam int RH = 4;
  localparam int LT = 20;
  localparam int LS = 8;
  localparam int MR = 3;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_HOLD     (RH),
    .LOCK_TIMEOUT (LT),
    .LOCK_STABLE  (LS),
    .MAX_RETRIES  (MR)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  // Reference model: phase plus absolute edge number at which its timer expires.
  int     m_mode = 0;
  int     m_retry = 0;
  longint edge_n = 0;
  longint deadline = 0;
  bit     s1 = 1'b0, s2 = 1'b0;

  task go_phase(input int mode, input int dur);
    m_mode   = mode;
    deadline = edge_n + dur;
  endtask

  task fail_attempt();
    if (m_retry == MR - 1) begin
      m_retry = (m_retry < 3) ? m_retry + 1 : 3;
      m_mode  = 4;
    end else begin
      m_retry = m_retry + 1;
      go_phase(0, RH);
    end
  endtask

  always @(posedge refclk) begin
    bit       lk;
    bit [9:0] exp_v, act_v;
    lk = s2;
    edge_n = edge_n + 1;
    if (!rst_n) begin
      s1 = 1'b0;
      s2 = 1'b0;
      m_retry = 0;
      go_phase(0, RH);
    end else begin
      s2 = s1;
      s1 = pll_locked;
      if (relock_req) begin
        m_retry = 0;
        go_phase(0, RH);
      end else begin
        case (m_mode)
          0: if (edge_n == deadline) go_phase(1, LT);
          1: begin
            if (lk) go_phase(2, LS);
            else if (edge_n == deadline) fail_attempt();
          end
          2: begin
            if (!lk) fail_attempt();
            else if (edge_n == deadline) begin
              m_mode  = 3;
              m_retry = 0;
            end
          end
          3: if (!lk) begin
            m_retry = 0;
            go_phase(0, RH);
          end
          default: ;
        endcase
      end
    end
    #1;
    exp_v = {3'(m_mode), (m_mode == 0 || m_mode == 4), (m_mode == 3), (m_mode == 3),
             (m_mode == 4), 2'(m_retry)};
    act_v = {state, pll_rst, sys_rst_n, ready, fault, retry_cnt};
    total = total + 1;
    if (act_v !== exp_v) begin
      bad = bad + 1;
      $display("FAIL cycle_model edge=%0d {state,pll_rst,sys_rst_n,ready,fault,retry} got=%b expected=%b",
               edge_n, act_v, exp_v);
    end
  end

  task chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Two reset edges with pll_locked preset, released at a falling edge.
  task do_reset(input bit lk_val);
    rst_n      = 1'b0;
    relock_req = 1'b0;
    pll_locked = lk_val;
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
  endtask

  initial begin
    int prst_i, rdy_i, flt_i;

    // Normal bring-up: lock arrives at the 10th edge after release.
    do_reset(1'b0);
    prst_i = -1;
    rdy_i  = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge refclk);
      if (i == 9) pll_locked = 1'b1;
      if (pll_rst == 1'b0 && prst_i < 0) prst_i = i;
      if (ready == 1'b1 && rdy_i < 0) begin
        rdy_i = i;
        chk("bringup_sys_rst_n", int'(sys_rst_n), 1);
      end
    end
    chk("bringup_pll_rst_release", prst_i, 3);
    chk("bringup_ready_cycle", rdy_i, 20);

    // One-cycle lock loss in RUN: new sequence, no retry counted.
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    @(negedge refclk);
    @(negedge refclk);
    chk("lockloss_ready", int'(ready), 0);
    chk("lockloss_pll_rst", int'(pll_rst), 1);
    chk("lockloss_retry", int'(retry_cnt), 0);
    repeat (28) @(negedge refclk);
    chk("lockloss_relocked", int'(ready), 1);

    // Lock never arrives: three 24-cycle attempts, then FAULT.
    do_reset(1'b0);
    flt_i = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge refclk);
      if (i == 23) chk("nolock_retry1", int'(retry_cnt), 1);
      if (i == 47) chk("nolock_retry2", int'(retry_cnt), 2);
      if (fault == 1'b1 && flt_i < 0) begin
        flt_i = i;
        chk("nolock_retry3", int'(retry_cnt), 3);
        chk("nolock_pll_rst", int'(pll_rst), 1);
      end
    end
    chk("nolock_fault_cycle", flt_i, 71);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    chk("relock_from_fault_state", int'(state), 0);
    chk("relock_from_fault_retry", int'(retry_cnt), 0);

    // Glitchy lock: high 5 cycles, drops inside STABILIZE.
    do_reset(1'b1);
    rdy_i = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge refclk);
      if (i == 4) pll_locked = 1'b0;
      if (i == 7) begin
        chk("glitch_retry", int'(retry_cnt), 1);
        chk("glitch_state", int'(state), 0);
      end
      if (ready == 1'b1) rdy_i = i;
    end
    chk("glitch_never_ready", rdy_i, -1);

    // Reset pulse during STABILIZE.
    do_reset(1'b1);
    repeat (7) @(negedge refclk);
    chk("pre_reset_in_stabilize", int'(state), 2);
    rst_n = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;
    chk("midreset_outputs", int'({state, pll_rst, sys_rst_n, ready, fault, retry_cnt}),
        int'(10'b000_1_0_0_0_00));

    // relock_req on the cycle STABILIZE would complete.
    do_reset(1'b1);
    repeat (12) @(negedge refclk);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    chk("relock_beats_run_state", int'(state), 0);
    chk("relock_beats_run_ready", int'(ready), 0);

    // Randomized stimulus; the per-cycle model check does the work here.
    for (int i = 0; i < 3000; i++) begin
      @(negedge refclk);
      rst_n      = ($urandom_range(0, 299) != 0);
      relock_req = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) pll_locked = ~pll_locked;
    end

    @(negedge refclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD, default 16, meaning refclk cycles pll_rst is held high per attempt (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000, meaning refclk cycles allowed for lock per attempt (1 ms at 50 MHz).
REQ-003 SHALL have parameter LOCK_STABLE, default 1024, meaning consecutive synchronized-locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, meaning failed attempts tolerated before FAULT (1..3).
REQ-005 refclk  input  1  sole clock, 50 MHz board reference.
REQ-006 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 pll_locked  input  1  PLL locked indication, asynchronous to refclk.
REQ-008 relock_req  input  1  single-cycle request to restart the sequence.
REQ-009 pll_rst  output  1  active-high reset to PLL.
REQ-010 sys_rst_n  output  1  active-low reset to downstream video logic (refclk domain; consumers resynchronize).
REQ-011 ready  output  1  high only in RUN.
REQ-012 fault  output  1  high only in FAULT.
REQ-013 retry_cnt  output  2  failed attempts in current sequence.
REQ-014 state  output  3  current state encoding, for debug.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; all logic uses synchronized lk; 2-cycle input latency.
REQ-016 States SHALL be HOLD=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4; one shared 16-bit down-counter cnt.
REQ-017 HOLD: pll_rst=1, sys_rst_n=0; cnt loaded RST_HOLD-1 on entry; at cnt==0 -> WAIT_LOCK, load LOCK_TIMEOUT-1.
REQ-018 WAIT_LOCK: pll_rst=0, sys_rst_n=0; lk=1 -> STABILIZE, load LOCK_STABLE-1; else at cnt==0 -> failed attempt.
REQ-019 STABILIZE: pll_rst=0, sys_rst_n=0; lk=0 -> failed attempt; at cnt==0 with lk=1 -> RUN.
REQ-020 Failed attempt: if retry_cnt==MAX_RETRIES-1 -> FAULT with retry_cnt incremented (saturating at 3); else retry_cnt+1 and -> HOLD.
REQ-021 RUN: pll_rst=0, sys_rst_n=1, ready=1, retry_cnt cleared on entry; lk=0 for one cycle -> HOLD with retry_cnt=0 (lock loss is a new sequence, not a retry).
REQ-022 FAULT: pll_rst=1, sys_rst_n=0, fault=1; remains until relock_req or reset.
REQ-023 relock_req in any state SHALL -> HOLD next cycle, retry_cnt=0, cnt=RST_HOLD-1; it overrides every other transition in the same cycle.
REQ-024 lk dropping in the same cycle cnt reaches 0 in STABILIZE SHALL count as failure, not RUN.
REQ-025 All outputs SHALL be registered; sys_rst_n and ready change in the same cycle as state.
REQ-026 Counter SHALL never wrap: load at entry only, decrement when nonzero.

Reset
REQ-027 While rst_n=0 at a refclk edge: state=HOLD, cnt=RST_HOLD-1, retry_cnt=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, synchronizer flops=0.
REQ-028 Reset mid-operation (any state) SHALL abort immediately to the reset values above; no partial sequence is resumed.
REQ-029 Reset SHALL need no running PLL output; only refclk is used.

Structure
REQ-030 State encoding constants and default parameter values SHALL live in shared package vga_clk_pkg.
REQ-031 The 2-flop synchronizer SHALL be sub-module sync_2ff (1-bit, reset value 0), instantiated once.
REQ-032 Target 150-250 lines RTL; no vendor primitives; PLL wrapper stays a separate instance driven by pll_rst.

Verification (RST_HOLD=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=3)
REQ-033 Normal bring-up: release rst_n, pll_locked rises cycle 10 and stays -> pll_rst low after 4 cycles, ready=1 and sys_rst_n=1 exactly 8 cycles after synchronized lock.
REQ-034 Lock never arrives -> three HOLD/WAIT_LOCK attempts of 24 cycles each, retry_cnt 1,2,3, fault=1, pll_rst=1; relock_req then -> HOLD, retry_cnt=0.
REQ-035 Glitchy lock: pll_locked high 5 cycles then low in STABILIZE -> retry_cnt=1, back to HOLD, ready never asserted.
REQ-036 Lock loss in RUN: drop pll_locked 1 cycle -> within 3 cycles ready=0, sys_rst_n=0, pll_rst=1, retry_cnt=0, re-locks to RUN.
REQ-037 rst_n low for 1 cycle during STABILIZE -> all outputs at reset values next cycle, sequence restarts from HOLD.
REQ-038 relock_req coincident with STABILIZE cnt==0 -> HOLD, not RUN.
